// File: rtl/spi_flash_read_seq.sv
// SPI flash READ sequencer: drives the SPI interface register port to send opcode/address/dummy
// bytes and streams payload bytes back. Define SPI_FAST_READ_EN for FAST READ (0x0B + dummy byte).
module spi_flash_read_seq #(
    parameter int         TIMEOUT  = 1024,
    parameter logic [1:0] FREQ_SEL = 2'b01
) (
    input  logic        bus2ip_clk,
    input  logic        rst,
    input  logic        req,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        done,
    output logic        err,
    output logic        m_wr,
    output logic        m_rd,
    output logic [1:0]  m_addr,
    output logic [8:0]  m_data,
    input  logic        m_wrack,
    input  logic        m_rdack,
    input  logic [7:0]  m_rdata
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
    localparam logic [8:0] HDR    = 9'd5;
`else
    localparam logic [7:0] OPCODE = 8'h03;
    localparam logic [8:0] HDR    = 9'd4;
`endif

    localparam int            CW        = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        CFG_REL,
        TX_WR,
        TX_REL,
        RX_RD,
        DONE
    } state_t;

    state_t        state;
    logic [23:0]   addr_q;
    logic [8:0]    last_q;
    logic [8:0]    idx;
    logic [CW-1:0] wait_cnt;
    logic          timed_out;

    assign timed_out = (wait_cnt == WAIT_LAST);

    // TX FIFO word for byte k: header bytes first, dummy zeros after, EOF flag on the final byte.
    function automatic logic [8:0] tx_word(input logic [8:0] k, input logic [23:0] a,
                                           input logic [8:0] last);
        logic [7:0] b;
        case (k)
            9'd0:    b = OPCODE;
            9'd1:    b = a[23:16];
            9'd2:    b = a[15:8];
            9'd3:    b = a[7:0];
            default: b = 8'h00;
        endcase
        return {(k == last), b};
    endfunction

    always_ff @(posedge bus2ip_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            m_wr       <= 1'b0;
            m_rd       <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
        end else begin
            done       <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (len == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q   <= addr;
                            last_q   <= HDR + {1'b0, len} - 9'd1;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            m_wr     <= 1'b1;
                            m_addr   <= 2'd0;
                            m_data   <= {7'b0, FREQ_SEL};
                            wait_cnt <= '0;
                            state    <= CFG_WR;
                        end
                    end
                end
                CFG_WR: begin
                    if (m_wrack) begin
                        m_wr  <= 1'b0;
                        state <= CFG_REL;
                    end else if (timed_out) begin
                        m_wr  <= 1'b0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CFG_REL: begin
                    if (!m_wrack) begin
                        idx      <= 9'd0;
                        m_wr     <= 1'b1;
                        m_addr   <= 2'd2;
                        m_data   <= tx_word(9'd0, addr_q, last_q);
                        wait_cnt <= '0;
                        state    <= TX_WR;
                    end
                end
                TX_WR: begin
                    if (m_wrack) begin
                        m_wr  <= 1'b0;
                        state <= TX_REL;
                    end else if (timed_out) begin
                        m_wr  <= 1'b0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                TX_REL: begin
                    if (!m_wrack) begin
                        m_rd     <= 1'b1;
                        m_addr   <= 2'd3;
                        wait_cnt <= '0;
                        state    <= RX_RD;
                    end
                end
                // Header echoes are dropped; only bytes past the header reach the host.
                RX_RD: begin
                    if (m_rdack) begin
                        m_rd <= 1'b0;
                        idx  <= idx + 9'd1;
                        if (idx >= HDR) begin
                            data_out   <= m_rdata;
                            data_valid <= 1'b1;
                        end
                        if (idx == last_q) begin
                            state <= DONE;
                        end else begin
                            m_wr     <= 1'b1;
                            m_addr   <= 2'd2;
                            m_data   <= tx_word(idx + 9'd1, addr_q, last_q);
                            wait_cnt <= '0;
                            state    <= TX_WR;
                        end
                    end else if (timed_out) begin
                        m_rd  <= 1'b0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Randomized bench for spi_flash_read_seq: a register-port slave model plus a byte-level
// reference of the expected TX words and payload for each READ transaction.
module tb_spi_flash_read_seq;

    localparam int         TO   = 24;
    localparam logic [1:0] FREQ = 2'b01;
`ifdef SPI_FAST_READ_EN
    localparam int         HDR  = 5;
    localparam logic [7:0] OPC  = 8'h0B;
`else
    localparam int         HDR  = 4;
    localparam logic [7:0] OPC  = 8'h03;
`endif

    logic        bus2ip_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  len = '0;
    logic        busy, data_valid, done, err, m_wr, m_rd;
    logic [7:0]  data_out;
    logic [1:0]  m_addr;
    logic [8:0]  m_data;
    logic        m_wrack = 1'b0;
    logic        m_rdack = 1'b0;
    logic [7:0]  m_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  rx_bytes [0:259];
    logic [10:0] wr_log [$];
    logic [7:0]  got [$];
    int          tx_count = 0;
    int          rx_idx = 0;
    int          stall_idx = -1;
    int          stall_cycles = 0;
    int          stall_left = 0;
    bit          rx_dead = 1'b0;
    logic [8:0]  held = '0;

    spi_flash_read_seq #(.TIMEOUT(TO), .FREQ_SEL(FREQ)) dut (
        .bus2ip_clk(bus2ip_clk),
        .rst(rst),
        .req(req),
        .addr(addr),
        .len(len),
        .busy(busy),
        .data_out(data_out),
        .data_valid(data_valid),
        .done(done),
        .err(err),
        .m_wr(m_wr),
        .m_rd(m_rd),
        .m_addr(m_addr),
        .m_data(m_data),
        .m_wrack(m_wrack),
        .m_rdack(m_rdack),
        .m_rdata(m_rdata)
    );

    always #5 bus2ip_clk = ~bus2ip_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Slave model: one-cycle ack pulses, optional write stall on one TX byte, optional dead RX FIFO.
    always @(negedge bus2ip_clk) begin
        if (rst) begin
            m_wrack = 1'b0;
            m_rdack = 1'b0;
        end else begin
            if (m_wrack) begin
                m_wrack = 1'b0;
            end else if (m_wr) begin
                if (m_addr == 2'd2 && tx_count == stall_idx && stall_left > 0) begin
                    if (stall_left == stall_cycles) held = m_data;
                    else checkOutput("tx_hold_data", m_data, held);
                    stall_left--;
                end else begin
                    m_wrack = 1'b1;
                    wr_log.push_back({m_addr, m_data});
                    if (m_addr == 2'd2) tx_count++;
                end
            end
            if (m_rdack) begin
                m_rdack = 1'b0;
            end else if (m_rd && !rx_dead) begin
                m_rdack = 1'b1;
                m_rdata = (rx_idx < 260) ? rx_bytes[rx_idx] : 8'h00;
                rx_idx++;
            end
        end
    end

    task automatic applyStimulus(input logic [23:0] a, input int n_len, input int s_idx,
                                 input int s_cyc, input bit dead);
        int          n;
        int          cycles;
        int          rd_high;
        bit          finished;
        bit          busy_gap;
        bit          bus_seen;
        logic [7:0]  b;
        logic [10:0] exp_wr [$];
        n = HDR + n_len;
        for (int k = 0; k < 260; k++) rx_bytes[k] = 8'($urandom);
        tx_count = 0;
        rx_idx = 0;
        stall_idx = s_idx;
        stall_cycles = s_cyc;
        stall_left = s_cyc;
        rx_dead = dead;
        wr_log.delete();
        got.delete();

        exp_wr.push_back({2'd0, 7'd0, FREQ});
        for (int k = 0; k < n; k++) begin
            if (k == 0) b = OPC;
            else if (k <= 3) b = 8'((a >> (8 * (3 - k))) & 24'hFF);
            else b = 8'h00;
            exp_wr.push_back({2'd2, (k == n - 1), b});
            if (dead) break;
        end

        @(negedge bus2ip_clk);
        req = 1'b1;
        addr = a;
        len = 8'(n_len);
        if (n_len == 0) begin
            @(negedge bus2ip_clk);
            req = 1'b0;
            checkOutput("len0_done", done, 1);
            checkOutput("len0_busy", busy, 0);
            bus_seen = m_wr | m_rd;
            repeat (4) begin
                @(negedge bus2ip_clk);
                if (m_wr || m_rd) bus_seen = 1'b1;
            end
            checkOutput("len0_no_bus", bus_seen, 0);
            checkOutput("len0_wr_log", wr_log.size(), 0);
            return;
        end
        @(negedge bus2ip_clk);
        req = 1'b0;
        checkOutput("busy_start", busy, 1);
        checkOutput("err_cleared", err, 0);

        cycles = 0;
        rd_high = 0;
        finished = 1'b0;
        busy_gap = 1'b0;
        while (!finished && cycles < 6000) begin
            @(negedge bus2ip_clk);
            cycles++;
            if (data_valid) got.push_back(data_out);
            if (m_rd) rd_high++;
            if (done) finished = 1'b1;
            else if (!busy) busy_gap = 1'b1;
        end
        checkOutput("done_seen", finished, 1);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("busy_held", busy_gap, 0);
        checkOutput("err_at_done", err, dead);
        if (dead) checkOutput("rd_timeout_cycles", rd_high, TO);

        checkOutput("wr_count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            checkOutput($sformatf("wr_word%0d", i), wr_log[i], exp_wr[i]);

        checkOutput("dv_count", got.size(), dead ? 0 : n_len);
        for (int j = 0; j < got.size() && j < n_len; j++)
            checkOutput($sformatf("payload%0d", j), got[j], rx_bytes[HDR + j]);

        @(negedge bus2ip_clk);
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        int bound;
        int n_len;
        repeat (3) @(negedge bus2ip_clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_dv", data_valid, 0);
        checkOutput("rst_m_wr", m_wr, 0);
        checkOutput("rst_m_rd", m_rd, 0);
        checkOutput("rst_m_addr", m_addr, 0);
        checkOutput("rst_m_data", m_data, 0);
        rst = 1'b0;
        @(negedge bus2ip_clk);

        applyStimulus(24'h012345, 2, -1, 0, 1'b0);
        applyStimulus(24'($urandom), 0, -1, 0, 1'b0);
        applyStimulus(24'($urandom), 3, 2, 20, 1'b0);
        applyStimulus(24'($urandom), 4, -1, 0, 1'b1);
        checkOutput("err_sticky", err, 1);
        applyStimulus(24'($urandom), 1, -1, 0, 1'b0);

        // Async reset while a TX write is stalled, away from any clock edge.
        tx_count = 0;
        rx_idx = 0;
        stall_idx = 1;
        stall_cycles = 50;
        stall_left = 50;
        rx_dead = 1'b0;
        @(negedge bus2ip_clk);
        req = 1'b1;
        addr = 24'hABCDEF;
        len = 8'd3;
        @(negedge bus2ip_clk);
        req = 1'b0;
        bound = 0;
        while (!(m_wr && m_addr == 2'd2 && tx_count == 1) && bound < 200) begin
            @(negedge bus2ip_clk);
            bound++;
        end
        checkOutput("reach_tx_wr", bound < 200, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_m_wr", m_wr, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        @(negedge bus2ip_clk);
        rst = 1'b0;
        @(negedge bus2ip_clk);
        checkOutput("post_rst_done", done, 0);
        applyStimulus(24'h00F00D, 2, -1, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            n_len = $urandom_range(1, 12);
            applyStimulus(24'($urandom), n_len, $urandom_range(0, HDR + n_len - 1),
                          $urandom_range(0, 10), 1'b0);
        end
        applyStimulus(24'($urandom), 255, -1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
